// File: rtl/pmem_arb_pkg.sv
// Shared types and constants for the physical-memory arbiter between the I-cache and the D-cache.
package pmem_arb_pkg;

    localparam int unsigned ADDR_W      = 32;
    localparam int unsigned LINE_W      = 256;
    localparam int unsigned OFFSET_BITS = 5;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        I_BUSY = 2'd1,
        D_BUSY = 2'd2
    } arb_state_e;

    typedef enum logic {
        SRC_I = 1'b0,
        SRC_D = 1'b1
    } req_src_e;

    // Winner of a simultaneous request: whoever was not served last.
    function automatic req_src_e tie_winner(input req_src_e last_grant);
        if (last_grant == SRC_I) begin
            return SRC_D;
        end
        return SRC_I;
    endfunction

endpackage

// File: rtl/pmem_arb_wdog.sv
// Saturating busy-cycle counter with a sticky expiry flag.
module pmem_arb_wdog #(
    parameter int unsigned WDOG_CYCLES = 1024
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic busy,
    input  logic resp,
    output logic wdog_err
);

    localparam int unsigned CNT_W = (WDOG_CYCLES > 1) ? $clog2(WDOG_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WDOG_CYCLES - 1);

    logic [CNT_W-1:0] cnt;
    logic             stall;

    assign stall = busy && !resp;

    // Count stalled busy cycles; the flag sets on the stalled cycle that finds the counter at its limit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            wdog_err <= 1'b0;
        end else begin
            if (clear) begin
                cnt <= '0;
            end else if (stall && (cnt != CNT_MAX)) begin
                cnt <= cnt + CNT_W'(1);
            end
            if (!clear && stall && (cnt == CNT_MAX)) begin
                wdog_err <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/pmem_arbiter.sv
// Arbitrates the single pmem line port between the I-cache and the D-cache, one transaction at a time.
module pmem_arbiter #(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned LINE_W      = 256,
    parameter int unsigned WDOG_CYCLES = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_resp,
    output logic [LINE_W-1:0] i_rdata,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [LINE_W-1:0] d_wdata,
    output logic              d_resp,
    output logic [LINE_W-1:0] d_rdata,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_address,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic              pmem_resp,
    input  logic [LINE_W-1:0] pmem_rdata,
    output logic              proto_err,
    output logic              wdog_err
);

    import pmem_arb_pkg::arb_state_e;
    import pmem_arb_pkg::req_src_e;
    import pmem_arb_pkg::IDLE;
    import pmem_arb_pkg::I_BUSY;
    import pmem_arb_pkg::D_BUSY;
    import pmem_arb_pkg::SRC_I;
    import pmem_arb_pkg::SRC_D;
    import pmem_arb_pkg::tie_winner;

    arb_state_e        state;
    arb_state_e        next_state;
    req_src_e          last_grant;
    req_src_e          grant_src;
    logic              grant;
    logic              d_req;
    logic              busy;
    logic              op_write_q;
    logic [ADDR_W-1:0] addr_q;
    logic [LINE_W-1:0] wdata_q;

    assign d_req = d_read || d_write;
    assign busy  = (state != IDLE);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Grant selection and next state.
    always_comb begin
        next_state = state;
        grant      = 1'b0;
        grant_src  = SRC_I;
        unique case (state)
            IDLE: begin
                if (i_read && d_req) begin
                    grant     = 1'b1;
                    grant_src = tie_winner(last_grant);
                end else if (i_read) begin
                    grant     = 1'b1;
                    grant_src = SRC_I;
                end else if (d_req) begin
                    grant     = 1'b1;
                    grant_src = SRC_D;
                end
                if (grant) begin
                    if (grant_src == SRC_D) begin
                        next_state = D_BUSY;
                    end else begin
                        next_state = I_BUSY;
                    end
                end
            end
            I_BUSY, D_BUSY: begin
                if (pmem_resp) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Capture the winning request so the pmem side sees stable fields for the whole transaction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= SRC_D;
            addr_q     <= '0;
            wdata_q    <= '0;
            op_write_q <= 1'b0;
            proto_err  <= 1'b0;
        end else if (grant) begin
            last_grant <= grant_src;
            if (grant_src == SRC_D) begin
                addr_q     <= d_addr;
                wdata_q    <= d_wdata;
                op_write_q <= d_write;
                if (d_read && d_write) begin
                    proto_err <= 1'b1;
                end
            end else begin
                addr_q     <= i_addr;
                wdata_q    <= '0;
                op_write_q <= 1'b0;
            end
        end
    end

    assign pmem_read    = busy && !op_write_q;
    assign pmem_write   = busy && op_write_q;
    assign pmem_address = addr_q;
    assign pmem_wdata   = wdata_q;

    // Completion is forwarded only to the requester that owns the transaction; pmem_resp in IDLE is dropped.
    assign i_resp  = (state == I_BUSY) && pmem_resp;
    assign d_resp  = (state == D_BUSY) && pmem_resp;
    assign i_rdata = rst_n ? pmem_rdata : '0;
    assign d_rdata = rst_n ? pmem_rdata : '0;

    pmem_arb_wdog #(
        .WDOG_CYCLES (WDOG_CYCLES)
    ) u_wdog (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (grant),
        .busy     (busy),
        .resp     (pmem_resp),
        .wdog_err (wdog_err)
    );

endmodule

// File: tb/tb_pmem_arbiter.sv
// Directed bench for pmem_arbiter: arbitration order, field capture, error flags, async reset and watchdog.
module tb_pmem_arbiter;

    localparam int unsigned AW = 32;
    localparam int unsigned LW = 256;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          i_read;
    logic [AW-1:0] i_addr;
    logic          i_resp;
    logic [LW-1:0] i_rdata;
    logic          d_read;
    logic          d_write;
    logic [AW-1:0] d_addr;
    logic [LW-1:0] d_wdata;
    logic          d_resp;
    logic [LW-1:0] d_rdata;
    logic          pmem_read;
    logic          pmem_write;
    logic [AW-1:0] pmem_address;
    logic [LW-1:0] pmem_wdata;
    logic          pmem_resp;
    logic [LW-1:0] pmem_rdata;
    logic          proto_err;
    logic          wdog_err;

    int tests = 0;
    int fails = 0;

    pmem_arbiter #(
        .ADDR_W      (AW),
        .LINE_W      (LW),
        .WDOG_CYCLES (8)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_read       (i_read),
        .i_addr       (i_addr),
        .i_resp       (i_resp),
        .i_rdata      (i_rdata),
        .d_read       (d_read),
        .d_write      (d_write),
        .d_addr       (d_addr),
        .d_wdata      (d_wdata),
        .d_resp       (d_resp),
        .d_rdata      (d_rdata),
        .pmem_read    (pmem_read),
        .pmem_write   (pmem_write),
        .pmem_address (pmem_address),
        .pmem_wdata   (pmem_wdata),
        .pmem_resp    (pmem_resp),
        .pmem_rdata   (pmem_rdata),
        .proto_err    (proto_err),
        .wdog_err     (wdog_err)
    );

    always #5 clk = ~clk;

    task automatic chk1(input string tag, input logic got, input logic exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s observed=%b expected=%b", tag, got, exp);
        end
    endtask

    task automatic chka(input string tag, input logic [AW-1:0] got, input logic [AW-1:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic chkl(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        rst_n      = 1'b0;
        i_read     = 1'b0;
        i_addr     = '0;
        d_read     = 1'b0;
        d_write    = 1'b0;
        d_addr     = '0;
        d_wdata    = '0;
        pmem_resp  = 1'b0;
        pmem_rdata = '1;
        #3;
        chk1("rst_pmem_read", pmem_read, 1'b0);
        chk1("rst_pmem_write", pmem_write, 1'b0);
        chka("rst_pmem_address", pmem_address, 32'h0);
        chkl("rst_pmem_wdata", pmem_wdata, '0);
        chkl("rst_i_rdata", i_rdata, '0);
        chk1("rst_proto_err", proto_err, 1'b0);
        chk1("rst_wdog_err", wdog_err, 1'b0);

        step();
        rst_n = 1'b1;

        // Tie right after reset: I first, then D, then D beats a re-asserted I.
        i_read     = 1'b1;
        i_addr     = 32'h0000_0100;
        d_read     = 1'b1;
        d_addr     = 32'h0000_0200;
        pmem_rdata = {32{8'h11}};
        step(); settle();
        chk1("tie_i_pmem_read", pmem_read, 1'b1);
        chka("tie_i_addr", pmem_address, 32'h0000_0100);
        step();
        pmem_resp = 1'b1;
        i_addr    = 32'h0000_0140;
        settle();
        chk1("tie_i_resp", i_resp, 1'b1);
        chk1("tie_d_resp_idle", d_resp, 1'b0);
        chkl("tie_i_rdata", i_rdata, {32{8'h11}});
        step();
        pmem_resp = 1'b0;
        settle();
        chk1("tie_gap_read", pmem_read, 1'b0);
        step(); settle();
        chka("rr_d_addr", pmem_address, 32'h0000_0200);
        chk1("rr_d_read", pmem_read, 1'b1);
        step();
        pmem_resp  = 1'b1;
        pmem_rdata = {32{8'h22}};
        settle();
        chk1("rr_d_resp", d_resp, 1'b1);
        chk1("rr_i_resp_quiet", i_resp, 1'b0);
        chkl("rr_d_rdata", d_rdata, {32{8'h22}});
        step();
        pmem_resp = 1'b0;
        d_read    = 1'b0;
        settle();
        chk1("rr_gap_read", pmem_read, 1'b0);
        step(); settle();
        chka("rr_i_addr", pmem_address, 32'h0000_0140);
        chk1("rr_i_read", pmem_read, 1'b1);
        step();
        pmem_resp = 1'b1;
        settle();
        chk1("rr_i_resp", i_resp, 1'b1);
        step();
        pmem_resp = 1'b0;
        i_read    = 1'b0;
        settle();
        chk1("rr_end_read", pmem_read, 1'b0);

        // Single I read, memory answers in the fifth busy cycle.
        step();
        i_read = 1'b1;
        i_addr = 32'h0000_0060;
        settle();
        step(); settle();
        chk1("iread_strobe", pmem_read, 1'b1);
        chk1("iread_no_write", pmem_write, 1'b0);
        chka("iread_addr", pmem_address, 32'h0000_0060);
        for (int k = 0; k < 3; k++) begin
            step(); settle();
            chk1("iread_wait_resp", i_resp, 1'b0);
        end
        step();
        pmem_resp  = 1'b1;
        pmem_rdata = {32{8'hA5}};
        settle();
        chk1("iread_resp", i_resp, 1'b1);
        chkl("iread_rdata", i_rdata, {32{8'hA5}});
        chk1("iread_d_resp", d_resp, 1'b0);
        step();
        pmem_resp = 1'b0;
        i_read    = 1'b0;
        settle();
        chk1("iread_resp_once", i_resp, 1'b0);
        chk1("iread_strobe_drop", pmem_read, 1'b0);

        // D write-back with the request address changing mid-transaction.
        step();
        d_write = 1'b1;
        d_addr  = 32'h0000_1000;
        d_wdata = {8{32'hDEAD_BEEF}};
        settle();
        step();
        d_addr = 32'h0000_2000;
        settle();
        chk1("dwr_strobe", pmem_write, 1'b1);
        chk1("dwr_no_read", pmem_read, 1'b0);
        chka("dwr_addr", pmem_address, 32'h0000_1000);
        chkl("dwr_wdata", pmem_wdata, {8{32'hDEAD_BEEF}});
        step(); settle();
        chka("dwr_addr_stable", pmem_address, 32'h0000_1000);
        step();
        pmem_resp = 1'b1;
        settle();
        chk1("dwr_resp", d_resp, 1'b1);
        chk1("dwr_i_resp", i_resp, 1'b0);
        chka("dwr_addr_at_resp", pmem_address, 32'h0000_1000);
        step();
        pmem_resp = 1'b0;
        d_write   = 1'b0;
        settle();
        chk1("dwr_strobe_drop", pmem_write, 1'b0);
        chk1("dwr_resp_once", d_resp, 1'b0);

        // Stray pmem_resp while idle must not reach either cache.
        step();
        pmem_resp = 1'b1;
        settle();
        chk1("idle_resp_i", i_resp, 1'b0);
        chk1("idle_resp_d", d_resp, 1'b0);
        step();
        pmem_resp = 1'b0;
        settle();
        chk1("pre_proto_err", proto_err, 1'b0);

        // Read and write together at grant: write wins, sticky protocol error.
        d_read  = 1'b1;
        d_write = 1'b1;
        d_addr  = 32'h0000_0300;
        step(); settle();
        chk1("proto_write", pmem_write, 1'b1);
        chk1("proto_read", pmem_read, 1'b0);
        chk1("proto_err_set", proto_err, 1'b1);
        step();
        pmem_resp = 1'b1;
        settle();
        chk1("proto_resp", d_resp, 1'b1);
        step();
        pmem_resp = 1'b0;
        d_read    = 1'b0;
        d_write   = 1'b0;
        settle();
        chk1("proto_err_held", proto_err, 1'b1);
        chk1("proto_strobe_drop", pmem_write, 1'b0);
        chk1("wdog_quiet", wdog_err, 1'b0);

        // Asynchronous reset in the middle of an I read.
        step();
        i_read = 1'b1;
        i_addr = 32'h0000_0080;
        settle();
        step(); settle();
        chk1("arst_pre_read", pmem_read, 1'b1);
        #2;
        rst_n     = 1'b0;
        pmem_resp = 1'b1;
        #1;
        chk1("arst_read_drop", pmem_read, 1'b0);
        chka("arst_addr", pmem_address, 32'h0);
        chk1("arst_no_resp", i_resp, 1'b0);
        chkl("arst_rdata", i_rdata, '0);
        chk1("arst_proto_clr", proto_err, 1'b0);
        step(); settle();
        chk1("arst_held_read", pmem_read, 1'b0);
        pmem_resp = 1'b0;
        i_read    = 1'b0;
        step();
        rst_n = 1'b1;
        settle();

        // Memory never answers: watchdog flags after the eighth stalled busy cycle.
        i_read = 1'b1;
        i_addr = 32'h0000_00C0;
        step(); settle();
        chk1("wdog_busy", pmem_read, 1'b1);
        repeat (7) step();
        settle();
        chk1("wdog_not_yet", wdog_err, 1'b0);
        step(); settle();
        chk1("wdog_set", wdog_err, 1'b1);
        chk1("wdog_no_abort", pmem_read, 1'b1);
        step(); settle();
        chk1("wdog_sticky", wdog_err, 1'b1);

        rst_n = 1'b0;
        #2;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
